ram_access_arbiter: RTL and testbench

RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

---
 rtl/ram_access_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port-per-direction RAM.
// Optional macro ARB_INIT_SWEEP_EN: after reset, zero every RAM word before
// accepting commands.
module ram_access_arbiter #(
    parameter int unsigned RAM_WIDTH = 16,
    parameter int unsigned RAM_DEPTH = 8,
    parameter int unsigned ADDR_SIZE = 3
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [RAM_WIDTH-1:0] a_wdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [RAM_WIDTH-1:0] b_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [RAM_WIDTH-1:0] a_rdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [RAM_WIDTH-1:0] b_rdata,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic [ADDR_SIZE-1:0] ram_wr_ad,
    output logic [ADDR_SIZE-1:0] ram_rd_ad,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    input  logic [RAM_WIDTH-1:0] ram_data_out,
    output logic                 busy
);

    localparam logic IdA = 1'b0;
    localparam logic IdB = 1'b1;

    logic                 last_q, last_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 rd_tag_q, rd_tag_d;
    logic                 sweep_act;
    logic [ADDR_SIZE-1:0] sweep_addr;
    logic                 gnt_any;
    logic                 g_we;
    logic [ADDR_SIZE-1:0] g_addr;
    logic [RAM_WIDTH-1:0] g_wdata;

`ifdef ARB_INIT_SWEEP_EN
    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] cnt_q, cnt_d;

    // Sweep FSM: walk the counter over every word once, then stay in run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StInit: begin
                cnt_d = cnt_q + ADDR_SIZE'(1);
                if (cnt_q == ADDR_SIZE'(RAM_DEPTH - 1)) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    // Sweep state register; clr restarts the sweep from word 0.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sweep_act  = ~clr & (state_q == StInit);
    assign sweep_addr = cnt_q;
    assign busy       = clr | (state_q == StInit);
`else
    assign sweep_act  = 1'b0;
    assign sweep_addr = '0;
    assign busy       = clr;
`endif

    // Round-robin grant: on contention the side not granted last wins.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!busy) begin
            if (a_req && b_req) begin
                if (last_q == IdB) a_gnt = 1'b1;
                else               b_gnt = 1'b1;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    // Select the granted command.
    always_comb begin
        gnt_any = a_gnt | b_gnt;
        g_we    = b_gnt ? b_we    : a_we;
        g_addr  = b_gnt ? b_addr  : a_addr;
        g_wdata = b_gnt ? b_wdata : a_wdata;
    end

    // RAM port drive: sweep has priority (grants are blocked then anyway).
    always_comb begin
        ram_wr_en   = 1'b0;
        ram_rd_en   = 1'b0;
        ram_wr_ad   = '0;
        ram_rd_ad   = '0;
        ram_data_in = '0;
        if (sweep_act) begin
            ram_wr_en = 1'b1;
            ram_wr_ad = sweep_addr;
        end else if (gnt_any) begin
            if (g_we) begin
                ram_wr_en   = 1'b1;
                ram_wr_ad   = g_addr;
                ram_data_in = g_wdata;
            end else begin
                ram_rd_en = 1'b1;
                ram_rd_ad = g_addr;
            end
        end
    end

    // Next state for last-grant and the tagged pending read.
    always_comb begin
        last_d    = last_q;
        rd_pend_d = 1'b0;
        rd_tag_d  = rd_tag_q;
        if (gnt_any) begin
            last_d = b_gnt ? IdB : IdA;
            if (!g_we) begin
                rd_pend_d = 1'b1;
                rd_tag_d  = b_gnt ? IdB : IdA;
            end
        end
    end

    // Arbiter state register; reset makes A win the first contention.
    always_ff @(posedge clk) begin
        if (clr) begin
            last_q    <= IdB;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= IdA;
        end else begin
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
        end
    end

    // Route returning read data to the tagged requester; clr kills it.
    always_comb begin
        a_rvalid = rd_pend_q & ~clr & (rd_tag_q == IdA);
        b_rvalid = rd_pend_q & ~clr & (rd_tag_q == IdB);
        a_rdata  = a_rvalid ? ram_data_out : '0;
        b_rdata  = b_rvalid ? ram_data_out : '0;
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model.
module tb_ram_access_arbiter;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AW = 3;
`ifdef ARB_INIT_SWEEP_EN
    localparam int SweepCyc = D;
`else
    localparam int SweepCyc = 0;
`endif

    logic          clk = 1'b0;
    logic          clr;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [W-1:0]  a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [W-1:0]  a_rdata, b_rdata;
    logic          ram_wr_en, ram_rd_en;
    logic [AW-1:0] ram_wr_ad, ram_rd_ad;
    logic [W-1:0]  ram_data_in, ram_data_out;
    logic          busy;

    always #5 clk = ~clk;

    ram_access_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_SIZE(AW)) dut (
        .clk(clk), .clr(clr),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
        .ram_wr_ad(ram_wr_ad), .ram_rd_ad(ram_rd_ad),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .busy(busy)
    );

    // Environment RAM: write on clock, registered read.
    logic [W-1:0] env_mem [D];
    always @(posedge clk) begin
        if (ram_wr_en) env_mem[ram_wr_ad] <= ram_data_in;
        if (ram_rd_en) ram_data_out <= env_mem[ram_rd_ad];
    end

    // Reference model state.
    typedef struct {
        bit           id;
        logic [W-1:0] data;
    } rd_t;

    logic [W-1:0] ref_mem [D];
    int           m_last  = 1;
    int           m_sweep = 0;
    rd_t          m_rdq[$];
    bit           m_ga, m_gb;
    int           n_checks = 0;
    int           n_errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        bit            sweep, e_busy, ga, gb, e_wr, e_rd, have_ret, rv_a, rv_b;
        logic [AW-1:0] e_wad, e_rad;
        logic [W-1:0]  e_din, e_ra, e_rb;
        rd_t           ret;

        sweep  = !clr && m_sweep > 0;
        e_busy = clr || m_sweep > 0;
        ga     = !e_busy && a_req && (!b_req || m_last == 1);
        gb     = !e_busy && b_req && !ga;
        e_wr = 0; e_rd = 0; e_wad = '0; e_rad = '0; e_din = '0;
        if (sweep) begin
            e_wr  = 1;
            e_wad = AW'(D - m_sweep);
        end else if (ga) begin
            if (a_we) begin e_wr = 1; e_wad = a_addr; e_din = a_wdata; end
            else      begin e_rd = 1; e_rad = a_addr; end
        end else if (gb) begin
            if (b_we) begin e_wr = 1; e_wad = b_addr; e_din = b_wdata; end
            else      begin e_rd = 1; e_rad = b_addr; end
        end
        have_ret = m_rdq.size() > 0;
        if (have_ret) ret = m_rdq.pop_front();
        rv_a = have_ret && !clr && ret.id == 1'b0;
        rv_b = have_ret && !clr && ret.id == 1'b1;
        e_ra = rv_a ? ret.data : '0;
        e_rb = rv_b ? ret.data : '0;

        chk("busy", busy, e_busy);
        chk("a_gnt", a_gnt, ga);
        chk("b_gnt", b_gnt, gb);
        chk("ram_wr_en", ram_wr_en, e_wr);
        chk("ram_rd_en", ram_rd_en, e_rd);
        chk("ram_wr_ad", ram_wr_ad, e_wad);
        chk("ram_rd_ad", ram_rd_ad, e_rad);
        chk("ram_data_in", ram_data_in, e_din);
        chk("a_rvalid", a_rvalid, rv_a);
        chk("b_rvalid", b_rvalid, rv_b);
        chk("a_rdata", a_rdata, e_ra);
        chk("b_rdata", b_rdata, e_rb);

        m_ga = ga;
        m_gb = gb;
        if (clr) begin
            m_last  = 1;
            m_sweep = SweepCyc;
            m_rdq.delete();
        end else begin
            if (sweep) begin
                ref_mem[e_wad] = '0;
                m_sweep--;
            end
            if (ga || gb) m_last = gb ? 1 : 0;
            if (e_wr && !sweep) ref_mem[e_wad] = e_din;
            if (e_rd) m_rdq.push_back('{id: gb, data: ref_mem[e_rad]});
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic do_reset();
        idle_in();
        clr = 1;
        repeat (2) nxt();
        clr = 0;
    endtask

    task automatic sweep_wait(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk("sweep_busy", busy, 1);
            nxt();
        end
    endtask

    logic [W-1:0] fill_d [D];
    bit           a_hold, b_hold;

    initial begin
        for (int i = 0; i < D; i++) ref_mem[i] = '0;
        do_reset();
        sweep_wait(SweepCyc);

        // Fill every word with a known random value through requester A.
        for (int i = 0; i < D; i++) begin
            fill_d[i] = W'($urandom);
            a_req = 1; a_we = 1; a_addr = AW'(i); a_wdata = fill_d[i];
            @(negedge clk);
            chk("fill_gnt", a_gnt, 1);
            nxt();
        end
        idle_in();
        nxt();

        // Lone writer then read-back of address 5.
        do_reset();
        sweep_wait(SweepCyc);
        a_req = 1; a_we = 1; a_addr = 3'd5; a_wdata = 16'hA5A5;
        @(negedge clk);
        chk("lw_gnt", a_gnt, 1);
        chk("lw_wr_en", ram_wr_en, 1);
        chk("lw_wr_ad", ram_wr_ad, 5);
        chk("lw_din", ram_data_in, 16'hA5A5);
        nxt();
        a_we = 0;
        @(negedge clk);
        chk("lr_gnt", a_gnt, 1);
        chk("lr_rd_en", ram_rd_en, 1);
        chk("lr_rd_ad", ram_rd_ad, 5);
        chk("lr_rv_early", a_rvalid, 0);
        nxt();
        idle_in();
        @(negedge clk);
        chk("lr_rvalid", a_rvalid, 1);
        chk("lr_rdata", a_rdata, 16'hA5A5);
        nxt();

        // Contention: both read continuously for 4 cycles from reset.
        do_reset();
        sweep_wait(SweepCyc);
        a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 3'd1; b_addr = 3'd2;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin a_req = 0; b_req = 0; end
            @(negedge clk);
            if (i < 4) begin
                chk("ct_a_gnt", a_gnt, (i % 2 == 0));
                chk("ct_b_gnt", b_gnt, (i % 2 == 1));
            end
            if (i > 0) begin
                chk("ct_a_rv", a_rvalid, ((i - 1) % 2 == 0));
                chk("ct_b_rv", b_rvalid, ((i - 1) % 2 == 1));
                if ((i - 1) % 2 == 0) chk("ct_a_rdata", a_rdata, fill_d[1]);
                else                  chk("ct_b_rdata", b_rdata, fill_d[2]);
            end
            nxt();
        end

        // Write by A then immediate read of the same word by B.
        idle_in();
        a_req = 1; a_we = 1; a_addr = 3'd7; a_wdata = 16'h1234;
        @(negedge clk);
        chk("wr_gnt", a_gnt, 1);
        nxt();
        idle_in();
        b_req = 1; b_we = 0; b_addr = 3'd7;
        @(negedge clk);
        chk("rd_b_gnt", b_gnt, 1);
        nxt();
        idle_in();
        @(negedge clk);
        chk("wr_rd_b_rv", b_rvalid, 1);
        chk("wr_rd_b_data", b_rdata, 16'h1234);
        chk("wr_rd_a_rv", a_rvalid, 0);
        nxt();

        // Reset with a read outstanding.
        a_req = 1; a_we = 0; a_addr = 3'd5;
        @(negedge clk);
        chk("rm_gnt", a_gnt, 1);
        nxt();
        clr = 1; a_req = 1; b_req = 1;
        @(negedge clk);
        chk("rm_rv_n1", a_rvalid, 0);
        chk("rm_gnt_clr", a_gnt, 0);
        chk("rm_busy", busy, 1);
        nxt();
        clr = 0;
        idle_in();
        @(negedge clk);
        chk("rm_rv_n2", a_rvalid, 0);
        nxt();
        sweep_wait(SweepCyc > 0 ? SweepCyc - 1 : 0);
        a_req = 1; b_req = 1; a_addr = 3'd0; b_addr = 3'd0;
        @(negedge clk);
        chk("rm_first_a", a_gnt, 1);
        chk("rm_first_b", b_gnt, 0);
        nxt();
        idle_in();
        nxt();

        // Release of clr with A already requesting.
        clr = 1;
        nxt();
        clr = 0;
        a_req = 1; a_we = 0; a_addr = 3'd3;
        for (int c = 0; c < SweepCyc; c++) begin
            @(negedge clk);
            chk("sw_busy", busy, 1);
            chk("sw_gnt", a_gnt, 0);
            chk("sw_wr_en", ram_wr_en, 1);
            chk("sw_wr_ad", ram_wr_ad, c);
            chk("sw_din", ram_data_in, 0);
            nxt();
        end
        @(negedge clk);
        chk("rel_busy", busy, 0);
        chk("rel_gnt", a_gnt, 1);
        nxt();
        idle_in();
        nxt();

        // Random traffic with occasional resets.
        a_hold = 0;
        b_hold = 0;
        repeat (3000) begin
            if (!a_hold) begin
                a_req = ($urandom_range(0, 2) != 0); a_we = 1'($urandom_range(0, 1));
                a_addr = AW'($urandom); a_wdata = W'($urandom); a_hold = a_req;
            end
            if (!b_hold) begin
                b_req = ($urandom_range(0, 2) != 0); b_we = 1'($urandom_range(0, 1));
                b_addr = AW'($urandom); b_wdata = W'($urandom); b_hold = b_req;
            end
            clr = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            #1;
            if (m_ga) a_hold = 0;
            if (m_gb) b_hold = 0;
            nxt();
        end
        clr = 0;
        idle_in();
        repeat (3) nxt();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
